// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl
// Sweeps an inclusive address window [start_addr, end_addr] of a synchronous
// read memory and hands each word to a dump sink over valid/ready.
// One word is in flight at a time: READ issues the strobe, WAIT covers the
// memory latency, and OUTPUT holds the word until the sink takes it.
//
// Parameters:
//   ADDR_W  memory address width
//   DATA_W  memory word width
//   RD_LAT  memory read latency in cycles (1..4)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle pulse, begins a dump when idle
//   abort        terminates an active dump
//   start_addr   first address, sampled on accepted start
//   end_addr     last address (inclusive), sampled on accepted start
//   busy         sweep in progress
//   done         one-cycle pulse when the sweep completes or aborts
//   mem_rd_en    read strobe to memory
//   mem_addr     read address
//   mem_rd_data  read data, valid RD_LAT cycles after mem_rd_en
//   dump_valid   dump word available
//   dump_ready   sink accepts the word when dump_valid && dump_ready
//   dump_addr    address of the current dump word
//   dump_data    current dump word
//   checksum     running sum of handshaken words (only with
//                MEM_DUMP_CHECKSUM_EN defined)
//
// Build option: define MEM_DUMP_CHECKSUM_EN to add the checksum output.

module mem_dump_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_OUTPUT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // RD_LAT is at most 4, so the remaining-latency count fits in two bits.
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [1:0]        wait_cnt;

  // Sweep sequencer. The sweep ends on cur_addr == last_addr rather than on a
  // word count, so a full-range window and a wrapping window need no special
  // cases. Abort takes priority over a simultaneous handshake so that no word
  // is delivered once the sweep has been cancelled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      last_addr  <= '0;
      wait_cnt   <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            last_addr <= end_addr;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (abort) begin
            state <= S_DONE;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_DONE;
          end else if (wait_cnt == 2'd0) begin
            dump_data  <= mem_rd_data;
            dump_addr  <= cur_addr;
            dump_valid <= 1'b1;
            state      <= S_OUTPUT;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_OUTPUT: begin
          if (abort) begin
            dump_valid <= 1'b0;
            state      <= S_DONE;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            if (cur_addr == last_addr) begin
              state <= S_DONE;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              state    <= S_READ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and memory strobes decode directly from the registered state.
  always_comb begin
    busy      = (state == S_READ) || (state == S_WAIT) || (state == S_OUTPUT);
    done      = (state == S_DONE);
    mem_rd_en = (state == S_READ);
    mem_addr  = cur_addr;
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  // Sum of words the sink actually accepted; it is left untouched after the
  // sweep so the value can be read any time until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      checksum <= '0;
    end else if ((state == S_OUTPUT) && dump_valid && dump_ready && !abort) begin
      checksum <= checksum + dump_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb_mem_dump_ctrl
// Directed bench for mem_dump_ctrl. Two instances share clock and reset:
// dut1 uses RD_LAT=1 for the window, abort and reset scenarios, dut3 uses
// RD_LAT=3 with a randomly toggling dump_ready. Each instance reads from a
// small memory model whose word is addr ^ 0xA5A5 and which returns 0xDEAD
// when no read was issued, so a mistimed capture shows up as wrong data.

module tb_mem_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic        start1, abort1, dump_ready1;
  logic [15:0] start_addr1, end_addr1;
  logic        busy1, done1, mem_rd_en1, dump_valid1;
  logic [15:0] mem_addr1, mem_rd_data1, dump_addr1, dump_data1;

  logic        start3, abort3, dump_ready3;
  logic [15:0] start_addr3, end_addr3;
  logic        busy3, done3, mem_rd_en3, dump_valid3;
  logic [15:0] mem_addr3, mem_rd_data3, dump_addr3, dump_data3;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [15:0] checksum1, checksum3;
`endif

  int tests_run  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  mem_dump_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .start_addr(start_addr1), .end_addr(end_addr1),
    .busy(busy1), .done(done1), .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1),
    .mem_rd_data(mem_rd_data1), .dump_valid(dump_valid1), .dump_ready(dump_ready1),
    .dump_addr(dump_addr1), .dump_data(dump_data1)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum1)
`endif
  );

  mem_dump_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3),
    .start_addr(start_addr3), .end_addr(end_addr3),
    .busy(busy3), .done(done3), .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3),
    .mem_rd_data(mem_rd_data3), .dump_valid(dump_valid3), .dump_ready(dump_ready3),
    .dump_addr(dump_addr3), .dump_data(dump_data3)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum3)
`endif
  );

  // Memory models: one-stage and three-stage read pipelines.
  logic [15:0] pipe1;
  logic [15:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1    <= mem_rd_en1 ? (mem_addr1 ^ 16'hA5A5) : 16'hDEAD;
    pipe3[0] <= mem_rd_en3 ? (mem_addr3 ^ 16'hA5A5) : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign mem_rd_data1 = pipe1;
  assign mem_rd_data3 = pipe3[2];

  // Monitor, sampling on the falling edge away from the active edge.
  int          cyc = 0;
  logic [15:0] hs_addr1 [$];
  logic [15:0] hs_data1 [$];
  int          hs_cyc1 [$];
  int          done_cyc1 [$];
  int          rd_cnt1 = 0;

  logic [15:0] hs_addr3 [$];
  logic [15:0] hs_data3 [$];
  int          lat3 [$];
  int          rd_cyc3 = 0;
  int          stab_err3 = 0;
  logic        pv3 = 1'b0;
  logic        pr3 = 1'b0;
  logic [15:0] pa3 = '0;
  logic [15:0] pd3 = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dump_valid1 && dump_ready1) begin
      hs_addr1.push_back(dump_addr1);
      hs_data1.push_back(dump_data1);
      hs_cyc1.push_back(cyc);
    end
    if (done1) done_cyc1.push_back(cyc);
    if (mem_rd_en1) rd_cnt1 <= rd_cnt1 + 1;

    if (mem_rd_en3) rd_cyc3 <= cyc;
    if (dump_valid3 && !pv3) lat3.push_back(cyc - rd_cyc3);
    if (pv3 && !pr3 && (!dump_valid3 || dump_addr3 != pa3 || dump_data3 != pd3))
      stab_err3 <= stab_err3 + 1;
    if (dump_valid3 && dump_ready3) begin
      hs_addr3.push_back(dump_addr3);
      hs_data3.push_back(dump_data3);
    end
    pv3 <= dump_valid3;
    pr3 <= dump_ready3;
    pa3 <= dump_addr3;
    pd3 <= dump_data3;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulses start for one cycle on the selected instance.
  task automatic applyStimulus(input int sel, input logic [15:0] sa,
                               input logic [15:0] ea);
    @(posedge clk); #1;
    if (sel == 1) begin
      start1 = 1'b1; start_addr1 = sa; end_addr1 = ea;
    end else begin
      start3 = 1'b1; start_addr3 = sa; end_addr3 = ea;
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  // Waits for done1, then one more falling edge so the monitor has settled.
  task automatic waitDone1(input string tag, input int max_cycles);
    bit seen = 1'b0;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 1);
    @(negedge clk);
  endtask

  logic [15:0] exp_t1 [4] = '{16'hA5B5, 16'hA5B4, 16'hA5B7, 16'hA5B6};
  logic [15:0] exp_a3 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] exp_d3 [4] = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, dbase, rbase, nrd;
    bit seen;

    reset = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; dump_ready1 = 1'b0; start_addr1 = '0; end_addr1 = '0;
    start3 = 1'b0; abort3 = 1'b0; dump_ready3 = 1'b0; start_addr3 = '0; end_addr3 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ctrl", 32'({busy1, done1, mem_rd_en1, dump_valid1}), 0);
    checkOutput("rst_mem_addr", 32'(mem_addr1), 0);
    checkOutput("rst_dump_addr", 32'(dump_addr1), 0);
    checkOutput("rst_dump_data", 32'(dump_data1), 0);

    // Window 0x10..0x13 with the sink always ready.
    $display("[TB] window 0x0010..0x0013");
    dump_ready1 = 1'b1;
    base = hs_addr1.size(); dbase = done_cyc1.size();
    applyStimulus(1, 16'h0010, 16'h0013);
    checkOutput("t1_busy", 32'(busy1), 1);
    checkOutput("t1_rd_en", 32'(mem_rd_en1), 1);
    checkOutput("t1_mem_addr", 32'(mem_addr1), 'h10);
    waitDone1("t1_done_seen", 60);
    checkOutput("t1_count", hs_addr1.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_addr", 32'(hs_addr1[base+i]), 'h10 + i);
      checkOutput("t1_data", 32'(hs_data1[base+i]), 32'(exp_t1[i]));
    end
    checkOutput("t1_done_count", done_cyc1.size() - dbase, 1);
    checkOutput("t1_done_gap", done_cyc1[dbase] - hs_cyc1[base+3], 1);
    checkOutput("t1_after", 32'({busy1, done1}), 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    checkOutput("t1_checksum", 32'(checksum1), 'h96D6);
`endif

    // Single-word window, with a second start pulse while busy.
    $display("[TB] window 0x0005..0x0005");
    base = hs_addr1.size(); rbase = rd_cnt1;
    applyStimulus(1, 16'h0005, 16'h0005);
    applyStimulus(1, 16'h0100, 16'h0200);
    waitDone1("t2_done_seen", 40);
    repeat (4) @(negedge clk);
    checkOutput("t2_count", hs_addr1.size() - base, 1);
    checkOutput("t2_addr", 32'(hs_addr1[base]), 'h5);
    checkOutput("t2_data", 32'(hs_data1[base]), 'hA5A0);
    checkOutput("t2_reads", rd_cnt1 - rbase, 1);
    checkOutput("t2_idle", 32'(busy1), 0);

    // Wrapping window.
    $display("[TB] window 0xFFFE..0x0001");
    base = hs_addr1.size();
    applyStimulus(1, 16'hFFFE, 16'h0001);
    waitDone1("t3_done_seen", 60);
    checkOutput("t3_count", hs_addr1.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_addr", 32'(hs_addr1[base+i]), 32'(exp_a3[i]));
      checkOutput("t3_data", 32'(hs_data1[base+i]), 32'(exp_d3[i]));
    end

    // Abort during the 10th READ of a 256-word window.
    $display("[TB] abort at 10th read");
    base = hs_addr1.size(); dbase = done_cyc1.size(); rbase = rd_cnt1;
    applyStimulus(1, 16'h0000, 16'h00FF);
    nrd = 0;
    for (int k = 0; k < 200; k++) begin
      if (mem_rd_en1) begin
        nrd++;
        if (nrd == 10) begin
          abort1 = 1'b1;
          @(posedge clk); #1;
          abort1 = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    checkOutput("t5_reached_10th", nrd, 10);
    waitDone1("t5_done_seen", 10);
    repeat (5) @(negedge clk);
    checkOutput("t5_count", hs_addr1.size() - base, 9);
    for (int i = 0; i < 9; i++) begin
      checkOutput("t5_addr", 32'(hs_addr1[base+i]), i);
      checkOutput("t5_data", 32'(hs_data1[base+i]), 32'(i) ^ 'hA5A5);
    end
    checkOutput("t5_reads", rd_cnt1 - rbase, 10);
    checkOutput("t5_done_count", done_cyc1.size() - dbase, 1);
    checkOutput("t5_valid", 32'(dump_valid1), 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    checkOutput("t5_checksum", 32'(checksum1), 'hD2C9);
`endif

    // Reset while a word waits in OUTPUT, then a normal sweep.
    $display("[TB] reset in OUTPUT");
    dump_ready1 = 1'b0;
    applyStimulus(1, 16'h0020, 16'h0030);
    for (int k = 0; k < 20; k++) begin
      if (dump_valid1) break;
      @(posedge clk); #1;
    end
    checkOutput("t6_in_output", 32'(dump_valid1), 1);
    dbase = done_cyc1.size();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_ctrl", 32'({busy1, done1, mem_rd_en1, dump_valid1}), 0);
    checkOutput("t6_mem_addr", 32'(mem_addr1), 0);
    checkOutput("t6_dump_addr", 32'(dump_addr1), 0);
    checkOutput("t6_dump_data", 32'(dump_data1), 0);
    repeat (3) @(negedge clk);
    checkOutput("t6_no_done", done_cyc1.size() - dbase, 0);
    dump_ready1 = 1'b1;
    base = hs_addr1.size();
    applyStimulus(1, 16'h0040, 16'h0041);
    waitDone1("t6_done_seen", 40);
    checkOutput("t6_count", hs_addr1.size() - base, 2);
    checkOutput("t6_addr0", 32'(hs_addr1[base]), 'h40);
    checkOutput("t6_data0", 32'(hs_data1[base]), 'hA5E5);
    checkOutput("t6_addr1", 32'(hs_addr1[base+1]), 'h41);
    checkOutput("t6_data1", 32'(hs_data1[base+1]), 'hA5E4);

    // RD_LAT=3 with a randomly toggling sink.
    $display("[TB] RD_LAT=3 random ready");
    applyStimulus(3, 16'h0030, 16'h0037);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge clk); #1;
      dump_ready3 = 1'($urandom_range(0, 1));
      if (done3) seen = 1'b1;
    end
    dump_ready3 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t4_done_seen", 32'(seen), 1);
    checkOutput("t4_count", hs_addr3.size(), 8);
    for (int i = 0; i < 8 && i < hs_addr3.size(); i++) begin
      checkOutput("t4_addr", 32'(hs_addr3[i]), 'h30 + i);
      checkOutput("t4_data", 32'(hs_data3[i]), ('h30 + i) ^ 'hA5A5);
    end
    checkOutput("t4_stable", stab_err3, 0);
    checkOutput("t4_lat_count", lat3.size(), 8);
    // Capture 3 cycles after the READ cycle; valid is seen one cycle later.
    for (int i = 0; i < lat3.size(); i++)
      checkOutput("t4_latency", lat3[i], 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
